// File: rtl/context_addr_gen.sv
// Neighbourhood address sequencer: per accepted event, raster-scans the (dx,dy) disc
// of radius RADIUS around the pooled event cell, reading in-graph neighbours, then writes the centre.
module context_addr_gen #(
    parameter int GRAPH_SIZE = 128,
    parameter int RADIUS     = 3,
    parameter int POOL_SHIFT = 0,
    localparam int GBW       = $clog2(GRAPH_SIZE),
    localparam int OFS_W     = $clog2(RADIUS + 1) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [GBW-1:0]       ev_x,
    input  logic [GBW-1:0]       ev_y,
    input  logic [GBW-1:0]       ev_t,
    input  logic                 ev_p,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [2*GBW-1:0]     mem_addr,
    output logic [OFS_W-1:0]     mem_dx,
    output logic [OFS_W-1:0]     mem_dy,
    output logic [GBW+1:0]       mem_wdata,
    output logic                 mem_last,
    output logic                 busy
);

    localparam int CW  = GBW + 2;
    localparam int SQW = 2 * OFS_W + 2;
    localparam logic signed [OFS_W-1:0] R_POS = OFS_W'(RADIUS);
    localparam logic signed [OFS_W-1:0] R_NEG = OFS_W'(-RADIUS);
    localparam logic signed [CW-1:0]    GS_C  = CW'(GRAPH_SIZE >> POOL_SHIFT);
    localparam logic signed [SQW-1:0]   R_SQ  = SQW'(RADIUS * RADIUS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [OFS_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [GBW-1:0]          bx_q, bx_d, by_q, by_d, t_q, t_d;
    logic                    p_q, p_d;

    logic signed [CW-1:0]    cand_x_s, cand_y_s;
    logic signed [SQW-1:0]   dxe_s, dye_s, dist_s;
    logic                    cand_ok_s, advance_s;

    // Candidate cell and its validity, evaluated in signed arithmetic so edges never wrap.
    always_comb begin
        cand_x_s  = $signed({2'b00, bx_q}) + $signed({{(CW-OFS_W){dx_q[OFS_W-1]}}, dx_q});
        cand_y_s  = $signed({2'b00, by_q}) + $signed({{(CW-OFS_W){dy_q[OFS_W-1]}}, dy_q});
        dxe_s     = $signed({{(SQW-OFS_W){dx_q[OFS_W-1]}}, dx_q});
        dye_s     = $signed({{(SQW-OFS_W){dy_q[OFS_W-1]}}, dy_q});
        dist_s    = dxe_s * dxe_s + dye_s * dye_s;
        cand_ok_s = (dist_s <= R_SQ)
                  && !((dx_q == '0) && (dy_q == '0))
                  && !cand_x_s[CW-1] && (cand_x_s < GS_C)
                  && !cand_y_s[CW-1] && (cand_y_s < GS_C);
    end

    // Next-state logic and memory-port outputs derived from the registered state.
    always_comb begin
        state_d   = state_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        bx_d      = bx_q;
        by_d      = by_q;
        t_d       = t_q;
        p_d       = p_q;
        ev_ready  = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_last  = 1'b0;
        mem_addr  = '0;
        mem_dx    = '0;
        mem_dy    = '0;
        advance_s = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                ev_ready = !reset;
                if (ev_valid) begin
                    bx_d    = ev_x >> POOL_SHIFT;
                    by_d    = ev_y >> POOL_SHIFT;
                    t_d     = ev_t;
                    p_d     = ev_p;
                    dx_d    = R_NEG;
                    dy_d    = R_NEG;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                mem_valid = cand_ok_s;
                mem_addr  = {cand_y_s[GBW-1:0], cand_x_s[GBW-1:0]};
                mem_dx    = dx_q;
                mem_dy    = dy_q;
                // Skipped candidates cost one idle cycle; issued reads wait for the memory.
                advance_s = !cand_ok_s || mem_ready;
                if (advance_s) begin
                    if (dx_q == R_POS) begin
                        dx_d = R_NEG;
                        if (dy_q == R_POS) begin
                            dy_d    = R_NEG;
                            state_d = WRITE;
                        end else begin
                            dy_d = dy_q + OFS_W'(1);
                        end
                    end else begin
                        dx_d = dx_q + OFS_W'(1);
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            WRITE: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_last  = 1'b1;
                mem_addr  = {by_q, bx_q};
                if (mem_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_wdata = {t_q, p_q, 1'b1};

    // State, scan offsets and latched event; reset abandons any event in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dx_q    <= '0;
            dy_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            t_q     <= '0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            t_q     <= t_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_context_addr_gen.sv
// Scoreboard bench for context_addr_gen: expected op streams are queued on event acceptance
// and a monitor compares every memory handshake; directed scenarios add hand-computed checks.
module tb_context_addr_gen;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [2:0]  dx;
        logic [2:0]  dy;
        logic [8:0]  wdata;
        logic        last;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       ev_valid = 1'b0;
    logic [6:0] ev_x = '0, ev_y = '0, ev_t = '0;
    logic       ev_p = 1'b0;
    logic       mem_ready = 1'b1;
    logic       sel = 1'b0;
    logic       tog_mode = 1'b0;

    logic       d0_ev_ready, d0_mem_valid, d0_mem_we, d0_mem_last, d0_busy;
    logic [13:0] d0_mem_addr;
    logic [2:0] d0_mem_dx, d0_mem_dy;
    logic [8:0] d0_mem_wdata;
    logic       d1_ev_ready, d1_mem_valid, d1_mem_we, d1_mem_last, d1_busy;
    logic [13:0] d1_mem_addr;
    logic [2:0] d1_mem_dx, d1_mem_dy;
    logic [8:0] d1_mem_wdata;

    context_addr_gen #(.GRAPH_SIZE(128), .RADIUS(3), .POOL_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .ev_valid(ev_valid && !sel), .ev_ready(d0_ev_ready),
        .ev_x(ev_x), .ev_y(ev_y), .ev_t(ev_t), .ev_p(ev_p),
        .mem_valid(d0_mem_valid), .mem_ready(mem_ready), .mem_we(d0_mem_we),
        .mem_addr(d0_mem_addr), .mem_dx(d0_mem_dx), .mem_dy(d0_mem_dy),
        .mem_wdata(d0_mem_wdata), .mem_last(d0_mem_last), .busy(d0_busy)
    );

    context_addr_gen #(.GRAPH_SIZE(128), .RADIUS(3), .POOL_SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .ev_valid(ev_valid && sel), .ev_ready(d1_ev_ready),
        .ev_x(ev_x), .ev_y(ev_y), .ev_t(ev_t), .ev_p(ev_p),
        .mem_valid(d1_mem_valid), .mem_ready(mem_ready), .mem_we(d1_mem_we),
        .mem_addr(d1_mem_addr), .mem_dx(d1_mem_dx), .mem_dy(d1_mem_dy),
        .mem_wdata(d1_mem_wdata), .mem_last(d1_mem_last), .busy(d1_busy)
    );

    logic        m_ev_ready, m_valid, m_we, m_last, m_busy;
    logic [13:0] m_addr;
    logic [2:0]  m_dx, m_dy;
    logic [8:0]  m_wdata;

    always_comb begin
        m_ev_ready = sel ? d1_ev_ready  : d0_ev_ready;
        m_valid    = sel ? d1_mem_valid : d0_mem_valid;
        m_we       = sel ? d1_mem_we    : d0_mem_we;
        m_last     = sel ? d1_mem_last  : d0_mem_last;
        m_busy     = sel ? d1_busy      : d0_busy;
        m_addr     = sel ? d1_mem_addr  : d0_mem_addr;
        m_dx       = sel ? d1_mem_dx    : d0_mem_dx;
        m_dy       = sel ? d1_mem_dy    : d0_mem_dy;
        m_wdata    = sel ? d1_mem_wdata : d0_mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    op_t exp_q[$];
    int n_checks = 0, n_fail = 0;
    int n_acc = 0, acc_cyc = 0, acc_prev = 0, n_writes = 0, wr_cyc = 0;
    int ev_reads = 0, busy_cnt = 0, stall_n = 0;
    logic [13:0] first_addr, last_rd_addr, wr_addr;
    logic [2:0]  first_dx, first_dy;
    logic [8:0]  wr_wdata;
    logic dx_neg, dx_pos, dy_neg, dy_pos;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_expected(input int x, input int y, input int t, input int p, input int shift);
        int bx, by, gs, cx, cy;
        op_t o;
        bx = x >> shift;
        by = y >> shift;
        gs = 128 >> shift;
        for (int dy = -3; dy <= 3; dy++) begin
            for (int dx = -3; dx <= 3; dx++) begin
                cx = bx + dx;
                cy = by + dy;
                if ((dx * dx + dy * dy <= 9) && !(dx == 0 && dy == 0) &&
                    cx >= 0 && cx < gs && cy >= 0 && cy < gs) begin
                    o.we = 1'b0; o.addr = {7'(cy), 7'(cx)}; o.dx = 3'(dx); o.dy = 3'(dy);
                    o.wdata = '0; o.last = 1'b0;
                    exp_q.push_back(o);
                end
            end
        end
        o.we = 1'b1; o.addr = {7'(by), 7'(bx)}; o.dx = 3'd0; o.dy = 3'd0;
        o.wdata = {7'(t), 1'(p), 1'b1}; o.last = 1'b1;
        exp_q.push_back(o);
    endtask

    // Monitor: acceptance pushes expectations, handshakes pop and compare, stalls must hold.
    initial begin
        op_t e;
        logic prev_stall;
        logic [21:0] held;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (ev_valid && m_ev_ready) begin
                    push_expected(int'(ev_x), int'(ev_y), int'(ev_t), int'(ev_p), sel ? 1 : 0);
                    n_acc++;
                    acc_prev = acc_cyc;
                    acc_cyc  = cyc;
                    ev_reads = 0;
                    busy_cnt = 0;
                    {dx_neg, dx_pos, dy_neg, dy_pos} = 4'b0000;
                end
                if (m_busy) busy_cnt++;
                if (prev_stall) begin
                    stall_n++;
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_hold", 32'({m_we, m_last, m_addr, m_dx, m_dy}), 32'(held));
                end
                if (m_valid && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_op: got addr 0x%0h we %0d, expected no operation", m_addr, m_we);
                    end else begin
                        e = exp_q.pop_front();
                        chk("op_we", 32'(m_we), 32'(e.we));
                        chk("op_addr", 32'(m_addr), 32'(e.addr));
                        chk("op_dx", 32'(m_dx), 32'(e.dx));
                        chk("op_dy", 32'(m_dy), 32'(e.dy));
                        chk("op_last", 32'(m_last), 32'(e.last));
                        if (e.we) chk("op_wdata", 32'(m_wdata), 32'(e.wdata));
                    end
                    if (!m_we) begin
                        if (ev_reads == 0) begin
                            first_addr = m_addr; first_dx = m_dx; first_dy = m_dy;
                        end
                        last_rd_addr = m_addr;
                        ev_reads++;
                        if ($signed(m_dx) < 0) dx_neg = 1'b1;
                        if ($signed(m_dx) > 0) dx_pos = 1'b1;
                        if ($signed(m_dy) < 0) dy_neg = 1'b1;
                        if ($signed(m_dy) > 0) dy_pos = 1'b1;
                    end else begin
                        n_writes++;
                        wr_addr  = m_addr;
                        wr_wdata = m_wdata;
                        wr_cyc   = cyc;
                    end
                end
                prev_stall = m_valid && !mem_ready;
                held = {m_we, m_last, m_addr, m_dx, m_dy};
            end
        end
    end

    // Memory ready: always 1, or toggling every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_mode) mem_ready = ~mem_ready;
            else mem_ready = 1'b1;
        end
    end

    task automatic wait_accept();
        int start;
        start = n_acc;
        for (int i = 0; i < 200 && n_acc == start; i++) begin
            @(negedge clk);
            #1;
        end
        chk("accept_timeout", 32'(n_acc - start), 32'd1);
    endtask

    task automatic send_ev(input int x, input int y, input int t, input int p);
        @(posedge clk);
        #1;
        ev_valid = 1'b1; ev_x = 7'(x); ev_y = 7'(y); ev_t = 7'(t); ev_p = 1'(p);
        wait_accept();
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = !m_busy && (exp_q.size() == 0);
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int w0, a0, a_first, wr_first;
        #2;
        chk("rst_mem_valid", 32'(d0_mem_valid), 32'd0);
        chk("rst_busy", 32'(d0_busy), 32'd0);
        chk("rst_ev_ready", 32'(d0_ev_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("ev_ready_after_rst", 32'(d0_ev_ready), 32'd1);

        // 1: centred event, full disc
        send_ev(64, 64, 10, 1);
        wait_done();
        chk("t1_reads", 32'(ev_reads), 32'd28);
        chk("t1_first_addr", 32'(first_addr), 32'({7'd61, 7'd64}));
        chk("t1_first_dx", 32'(first_dx), 32'd0);
        chk("t1_first_dy", 32'(first_dy), 32'(3'b101));
        chk("t1_last_addr", 32'(last_rd_addr), 32'({7'd67, 7'd64}));
        chk("t1_wr_addr", 32'(wr_addr), 32'({7'd64, 7'd64}));
        chk("t1_wdata", 32'(wr_wdata), 32'({7'd10, 1'b1, 1'b1}));
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd50);
        chk("t1_writes", 32'(n_writes), 32'd1);

        // 2: corner event, only the non-negative quadrant survives
        send_ev(0, 0, 5, 0);
        wait_done();
        chk("t2_reads", 32'(ev_reads), 32'd10);
        chk("t2_first_addr", 32'(first_addr), 32'({7'd0, 7'd1}));
        chk("t2_no_neg", 32'({dx_neg, dy_neg}), 32'd0);
        chk("t2_wr_addr", 32'(wr_addr), 32'd0);

        // 3: alternating mem_ready
        tog_mode = 1'b1;
        send_ev(64, 64, 20, 0);
        wait_done();
        tog_mode = 1'b0;
        chk("t3_reads", 32'(ev_reads), 32'd28);
        chk("t3_stalls_seen", 32'(stall_n > 10), 32'd1);

        // 4: pooled instance, far corner
        @(posedge clk);
        #1 sel = 1'b1;
        send_ev(127, 127, 33, 1);
        wait_done();
        chk("t4_reads", 32'(ev_reads), 32'd10);
        chk("t4_no_pos", 32'({dx_pos, dy_pos}), 32'd0);
        chk("t4_wr_addr", 32'(wr_addr), 32'({7'd63, 7'd63}));
        @(posedge clk);
        #1 sel = 1'b0;

        // 5: reset after the 5th read handshake abandons the event
        w0 = n_writes;
        send_ev(64, 64, 7, 1);
        for (int i = 0; i < 200 && ev_reads < 5; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t5_reached_5", 32'(ev_reads), 32'd5);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_valid_in_rst", 32'(d0_mem_valid), 32'd0);
        chk("t5_busy_in_rst", 32'(d0_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        chk("t5_no_partial_write", 32'(n_writes - w0), 32'd0);
        send_ev(10, 10, 3, 0);
        wait_done();
        chk("t5_reads", 32'(ev_reads), 32'd28);
        chk("t5_first_dy", 32'(first_dy), 32'(3'b101));
        chk("t5_first_addr", 32'(first_addr), 32'({7'd7, 7'd10}));
        chk("t5_writes", 32'(n_writes - w0), 32'd1);

        // 6: ev_valid held across two back-to-back events
        w0 = n_writes;
        a0 = n_acc;
        @(posedge clk);
        #1;
        ev_valid = 1'b1; ev_x = 7'd30; ev_y = 7'd40; ev_t = 7'd1; ev_p = 1'b0;
        wait_accept();
        @(posedge clk);
        #1;
        ev_x = 7'd50; ev_y = 7'd60; ev_t = 7'd2; ev_p = 1'b1;
        wait_accept();
        a_first  = acc_prev;
        wr_first = wr_cyc;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        chk("t6_accepts", 32'(n_acc - a0), 32'd2);
        chk("t6_period", 32'(acc_cyc - a_first), 32'd51);
        chk("t6_accept_after_write", 32'(acc_cyc - wr_first), 32'd1);
        chk("t6_writes", 32'(n_writes - w0), 32'd2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
